csa_pipe: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor. It is the successor to the fixed 8-bit combinational csa_8.
- Operands are split into BLK-bit blocks; each pipeline stage resolves one block's carry-select, so throughput is one operation per cycle.
- Sits on a valid/ready stream between the operand source and the result consumer, with full backpressure.
- Adds subtract mode, carry-in, and signed-overflow reporting.

---
 rtl/csa_pkg.sv | 34 +++
 rtl/csa_block.sv | 24 ++
 rtl/csa_pipe.sv | 104 ++++++++++
 tb/tb_csa_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
// Holds the reference result type and the golden arithmetic model.
package csa_pkg;

  localparam int CSA_MAXW = 64;

  typedef struct packed {
    logic [CSA_MAXW-1:0] sum;
    logic                carry;
    logic                ovf;
  } csa_res_t;

  // Golden {carry, sum, ovf} for an operation of the given width (1..64).
  function automatic csa_res_t csa_golden(input logic [CSA_MAXW-1:0] a,
                                          input logic [CSA_MAXW-1:0] b,
                                          input logic                cin,
                                          input logic                sub,
                                          input int                  width);
    logic [CSA_MAXW:0]   full;
    logic [CSA_MAXW-1:0] mask;
    logic [CSA_MAXW-1:0] am;
    logic [CSA_MAXW-1:0] be;
    csa_res_t            r;
    mask    = (width >= CSA_MAXW) ? '1 : ((64'(1) << width) - 64'(1));
    am      = a & mask;
    be      = (sub ? ~b : b) & mask;
    full    = {1'b0, am} + {1'b0, be} + 65'(sub | cin);
    r.sum   = full[CSA_MAXW-1:0] & mask;
    r.carry = full[width];
    r.ovf   = (am[width-1] == be[width-1]) && (r.sum[width-1] != am[width-1]);
    return r;
  endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select block: both carry-in candidates are formed in parallel
// and the registered carry from the previous block picks one.
module csa_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] i_a,
  input  logic [BLK-1:0] i_b,
  input  logic           i_cin_sel,
  output logic [BLK-1:0] o_sum,
  output logic           o_cout,
  output logic           o_cmsb
);

  logic [BLK:0] w_r0;
  logic [BLK:0] w_r1;

  assign w_r0   = {1'b0, i_a} + {1'b0, i_b};
  assign w_r1   = {1'b0, i_a} + {1'b0, i_b} + {{BLK{1'b0}}, 1'b1};
  assign o_sum  = i_cin_sel ? w_r1[BLK-1:0] : w_r0[BLK-1:0];
  assign o_cout = i_cin_sel ? w_r1[BLK]     : w_r0[BLK];
  // Carry into the MSB falls out of the MSB sum bit without a second adder.
  assign o_cmsb = o_sum[BLK-1] ^ i_a[BLK-1] ^ i_b[BLK-1];

endmodule

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder/subtractor, one BLK-bit block per stage,
// valid/ready stream with a single global stall enable.
module csa_pipe
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  localparam int NB = WIDTH / BLK;

  // Operands travel with the beat; slice k of s is filled in at stage k.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
  } stage_t;

  stage_t           r_stg [NB];
  stage_t           w_nxt [NB];
  logic             w_en;
  logic             w_acc;
  logic [WIDTH-1:0] w_beff;
  logic [BLK-1:0]   w_ba  [NB];
  logic [BLK-1:0]   w_bb  [NB];
  logic [BLK-1:0]   w_bs  [NB];
  logic             w_bci [NB];
  logic             w_bc  [NB];
  logic             w_bcm [NB];

  assign w_en     = !r_stg[NB-1].vld || out_ready;
  assign in_ready = w_en && !rst;
  assign w_acc    = in_valid && in_ready;
  assign w_beff   = sub ? ~b : b;

  generate
    for (genvar k = 0; k < NB; k++) begin : g_blk
      if (k == 0) begin : g_first
        assign w_ba[k]  = a[BLK-1:0];
        assign w_bb[k]  = w_beff[BLK-1:0];
        assign w_bci[k] = sub | cin;
      end else begin : g_rest
        assign w_ba[k]  = r_stg[k-1].a[k*BLK +: BLK];
        assign w_bb[k]  = r_stg[k-1].b[k*BLK +: BLK];
        assign w_bci[k] = r_stg[k-1].c;
      end
      csa_block #(.BLK(BLK)) u_blk (
        .i_a      (w_ba[k]),
        .i_b      (w_bb[k]),
        .i_cin_sel(w_bci[k]),
        .o_sum    (w_bs[k]),
        .o_cout   (w_bc[k]),
        .o_cmsb   (w_bcm[k])
      );
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < NB; k++) w_nxt[k] = '0;
    w_nxt[0].vld          = w_acc;
    w_nxt[0].a            = a;
    w_nxt[0].b            = w_beff;
    w_nxt[0].s[BLK-1:0]   = w_bs[0];
    w_nxt[0].c            = w_bc[0];
    w_nxt[0].ovf          = w_bcm[0] ^ w_bc[0];
    for (int k = 1; k < NB; k++) begin
      w_nxt[k]                  = r_stg[k-1];
      w_nxt[k].s[k*BLK +: BLK]  = w_bs[k];
      w_nxt[k].c                = w_bc[k];
      w_nxt[k].ovf              = w_bcm[k] ^ w_bc[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NB; k++) r_stg[k] <= '0;
    end else if (w_en) begin
      for (int k = 0; k < NB; k++) r_stg[k] <= w_nxt[k];
    end
  end

  assign out_valid = r_stg[NB-1].vld;
  assign sum       = r_stg[NB-1].s;
  assign carry     = r_stg[NB-1].c;
  assign ovf       = r_stg[NB-1].ovf;

endmodule

// File: tb/tb_csa_pipe.sv
// Scoreboard bench for csa_pipe: 32/8 directed + random, plus 8/8 and 24/4
// instances under random traffic and random backpressure.
module tb_csa_pipe;
  import csa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        iv, ir, ci, sb, ov, ordy, cy, of;
  logic [31:0] a, b, s;
  logic        iv8, ir8, ci8, sb8, ov8, ordy8, cy8, of8;
  logic [7:0]  a8, b8, s8;
  logic        iv24, ir24, ci24, sb24, ov24, ordy24, cy24, of24;
  logic [23:0] a24, b24, s24;

  csa_pipe #(.WIDTH(32), .BLK(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .cin(ci), .sub(sb), .out_valid(ov), .out_ready(ordy), .sum(s),
    .carry(cy), .ovf(of));

  csa_pipe #(.WIDTH(8), .BLK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(ci8), .sub(sb8), .out_valid(ov8), .out_ready(ordy8), .sum(s8),
    .carry(cy8), .ovf(of8));

  csa_pipe #(.WIDTH(24), .BLK(4)) u_dut24 (
    .clk(clk), .rst(rst), .in_valid(iv24), .in_ready(ir24), .a(a24), .b(b24),
    .cin(ci24), .sub(sb24), .out_valid(ov24), .out_ready(ordy24), .sum(s24),
    .carry(cy24), .ovf(of24));

  typedef struct {
    logic [63:0] sum;
    logic        carry;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a, b;
    logic        ci, sb;
    logic [31:0] s;
    logic        c, o;
  } vec_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t q24[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   vcnt     = 0;
  int   stallcnt = 0;
  bit   done32, done8, done24;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [63:0] s_,
                     input logic c_, input logic o_);
    chk({tag, "_sum"}, s_, e.sum);
    chk({tag, "_carry"}, 64'(c_), 64'(e.carry));
    chk({tag, "_ovf"}, 64'(o_), 64'(e.ovf));
  endtask

  task automatic unexpected(input string tag, input logic [63:0] s_);
    checks++;
    errors++;
    $display("FAIL %s output sum=%0h appeared, expected no output", tag, s_);
  endtask

  // Present one beat, wait (bounded) for acceptance, then log its expectation.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                      input logic ts, input logic [31:0] es, input logic ec,
                      input logic eo, input bit lat);
    exp_t e;
    int   n;
    a = ta; b = tb_; ci = tc; sb = ts; iv = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!ir && n < 200);
    if (!ir) begin
      checks++; errors++;
      $display("FAIL send32_timeout in_ready=0 after %0d cycles, expected 1", n);
    end else begin
      e.sum = 64'(es); e.carry = ec; e.ovf = eo; e.acc = cyc + 1; e.lat = lat;
      q32.push_back(e);
    end
    @(posedge clk); #1;
    iv = 1'b0;
  endtask

  task automatic send_rnd32(input logic [31:0] ta, input logic [31:0] tb_,
                            input logic tc, input logic ts);
    csa_res_t g;
    g = csa_golden(64'(ta), 64'(tb_), tc, ts, 32);
    send(ta, tb_, tc, ts, g.sum[31:0], g.carry, g.ovf, 1'b0);
  endtask

  task automatic send8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                       input logic ts);
    exp_t e;
    csa_res_t g;
    int n;
    g = csa_golden(64'(ta), 64'(tb_), tc, ts, 8);
    a8 = ta; b8 = tb_; ci8 = tc; sb8 = ts; iv8 = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!ir8 && n < 200);
    if (!ir8) begin
      checks++; errors++;
      $display("FAIL send8_timeout in_ready=0 after %0d cycles, expected 1", n);
    end else begin
      e.sum = g.sum; e.carry = g.carry; e.ovf = g.ovf; e.acc = cyc + 1; e.lat = 1'b0;
      q8.push_back(e);
    end
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic send24(input logic [23:0] ta, input logic [23:0] tb_, input logic tc,
                        input logic ts);
    exp_t e;
    csa_res_t g;
    int n;
    g = csa_golden(64'(ta), 64'(tb_), tc, ts, 24);
    a24 = ta; b24 = tb_; ci24 = tc; sb24 = ts; iv24 = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!ir24 && n < 200);
    if (!ir24) begin
      checks++; errors++;
      $display("FAIL send24_timeout in_ready=0 after %0d cycles, expected 1", n);
    end else begin
      e.sum = g.sum; e.carry = g.carry; e.ovf = g.ovf; e.acc = cyc + 1; e.lat = 1'b0;
      q24.push_back(e);
    end
    @(posedge clk); #1;
    iv24 = 1'b0;
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    while ((q32.size() + q8.size() + q24.size()) != 0 && n < 500) begin
      @(negedge clk); n++;
    end
    chk("drain_pending", 64'(q32.size() + q8.size() + q24.size()), 64'(0));
  endtask

  // Monitor for the 32-bit instance: scoreboard pop, stall behaviour, latency.
  initial begin : mon32
    exp_t        e;
    logic        pst;
    logic [33:0] pout;
    pst  = 1'b0;
    pout = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pst = 1'b0;
      end else begin
        if (ov) vcnt++;
        if (ov && !ordy) begin
          stallcnt++;
          chk("stall_in_ready", 64'(ir), 64'(0));
          if (pst) chk("stall_hold", 64'({s, cy, of}), 64'(pout));
        end
        pst  = ov && !ordy;
        pout = {s, cy, of};
        if (ov && ordy) begin
          if (q32.size() == 0) unexpected("unexpected32", 64'(s));
          else begin
            e = q32.pop_front();
            cmp("r32", e, 64'(s), cy, of);
            if (e.lat) chk("latency32", 64'(cyc - e.acc), 64'(3));
          end
        end
      end
    end
  end

  initial begin : mon8
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ov8 && ordy8) begin
        if (q8.size() == 0) unexpected("unexpected8", 64'(s8));
        else begin e = q8.pop_front(); cmp("r8", e, 64'(s8), cy8, of8); end
      end
    end
  end

  initial begin : mon24
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ov24 && ordy24) begin
        if (q24.size() == 0) unexpected("unexpected24", 64'(s24));
        else begin e = q24.pop_front(); cmp("r24", e, 64'(s24), cy24, of24); end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog simulation did not complete, expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stim
    vec_t vt[10];
    int   st0;
    vt[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vt[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[4] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    vt[5] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[6] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    vt[7] = '{32'h1234_5678, 32'h0FED_CBA8, 1'b0, 1'b0, 32'h2222_2220, 1'b0, 1'b0};
    vt[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vt[9] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

    rst = 1'b1;
    iv = 1'b0; a = '0; b = '0; ci = 1'b0; sb = 1'b0; ordy = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sb8 = 1'b0; ordy8 = 1'b1;
    iv24 = 1'b0; a24 = '0; b24 = '0; ci24 = 1'b0; sb24 = 1'b0; ordy24 = 1'b1;
    done32 = 1'b0; done8 = 1'b0; done24 = 1'b0;

    // Reset state, sampled while reset is still held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(ir), 64'(0));
    chk("rst_out_valid", 64'(ov), 64'(0));
    chk("rst_sum", 64'(s), 64'(0));
    chk("rst_carry", 64'(cy), 64'(0));
    chk("rst_ovf", 64'(of), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(ir), 64'(1));
    @(posedge clk); #1;

    // Single beat: latency and a one-cycle out_valid pulse.
    vcnt = 0;
    send(vt[0].a, vt[0].b, vt[0].ci, vt[0].sb, vt[0].s, vt[0].c, vt[0].o, 1'b1);
    repeat (8) @(negedge clk);
    chk("single_valid_cycles", 64'(vcnt), 64'(1));
    chk("single_drained", 64'(q32.size()), 64'(0));
    @(posedge clk); #1;

    // Directed ripple / subtract / overflow vectors, streamed back-to-back.
    for (int i = 1; i < 10; i++)
      send(vt[i].a, vt[i].b, vt[i].ci, vt[i].sb, vt[i].s, vt[i].c, vt[i].o, 1'b0);
    drain_all();
    @(posedge clk); #1;

    // Eight-beat burst with a three-cycle consumer stall in the middle.
    st0 = stallcnt;
    fork
      begin
        for (int i = 1; i <= 8; i++)
          send(32'(i), 32'h00FF_FFFF, 1'b0, 1'b0, 32'h00FF_FFFF + 32'(i), 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 ordy = 1'b0;
        repeat (3) @(posedge clk);
        #1 ordy = 1'b1;
      end
    join
    drain_all();
    chk("burst_stall_cycles", 64'(stallcnt - st0), 64'(3));
    @(posedge clk); #1;

    // Reset while three beats are in flight: nothing may emerge afterwards.
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    send(32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_000F, 1'b1, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    q32.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 64'(ov), 64'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_mid_no_stale", 64'(ov), 64'(0));
    end
    @(posedge clk); #1;

    // Random traffic on all three instances with random backpressure.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send_rnd32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done32 = 1'b1;
      end
      begin
        while (!done32) begin @(posedge clk); #1; ordy = ($urandom_range(0, 3) != 0); end
        ordy = 1'b1;
      end
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done8 = 1'b1;
      end
      begin
        while (!done8) begin @(posedge clk); #1; ordy8 = ($urandom_range(0, 2) != 0); end
        ordy8 = 1'b1;
      end
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          send24(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        done24 = 1'b1;
      end
      begin
        while (!done24) begin @(posedge clk); #1; ordy24 = ($urandom_range(0, 2) != 0); end
        ordy24 = 1'b1;
      end
    join
    drain_all();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
